// File: rtl/l2_cache_pkg.sv
// rtl/l2_cache_pkg.sv - shared widths, FSM states and line-entry field offsets for l2_read_cache
package l2_cache_pkg;

  localparam int ADDR_W   = 28;
  localparam int IDX_W    = 6;
  localparam int L2_LINES = 1 << IDX_W;
  localparam int TAG_W    = ADDR_W - IDX_W;
  localparam int LINE_W   = 128;

  // A line entry is packed as {valid, tag, data}, data in the low bits.
  localparam int DATA_LSB  = 0;
  localparam int TAG_LSB   = LINE_W;
  localparam int VALID_BIT = LINE_W + TAG_W;
  localparam int ENTRY_W   = LINE_W + TAG_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MISS = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/l2_line_array.sv
// rtl/l2_line_array.sv - direct-mapped {valid, tag, data} store: async read, sync write, sync valid clear
module l2_line_array
  import l2_cache_pkg::*;
(
  input  logic               clk,
  input  logic               clr,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [ENTRY_W-1:0] rd_entry,
  input  logic               we,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [LINE_W-1:0]  wr_data
);

  logic [TAG_W+LINE_W-1:0] lines [L2_LINES];
  logic [L2_LINES-1:0]     valid_q;

  assign rd_entry = {valid_q[rd_idx], lines[rd_idx]};

  // Tag/data are never cleared; only the valid bits carry reset state.
  always_ff @(posedge clk) begin
    if (we) lines[wr_idx] <= {wr_tag, wr_data};
  end

  always_ff @(posedge clk) begin
    if (clr) valid_q <= '0;
    else if (we) valid_q[wr_idx] <= 1'b1;
  end

endmodule

// File: rtl/l2_read_cache.sv
// rtl/l2_read_cache.sv - direct-mapped read-only L2 line cache; optional hit/miss counters under L2_STAT_EN
module l2_read_cache
  import l2_cache_pkg::*;
(
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              l1_read,
  input  logic [ADDR_W-1:0] l1_addr,
  output logic [LINE_W-1:0] l1_rdata,
  output logic              l1_ready,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
`ifdef L2_STAT_EN
  ,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
`endif
);

  state_t              state, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LINE_W-1:0]   rdata_d;
  logic [ADDR_W-1:0]   mem_addr_d;
  logic                ready_d, mem_read_d, fill_we;
  logic [ENTRY_W-1:0]  rd_entry;
  logic                rd_valid, hit;
  logic [TAG_W-1:0]    rd_tag;
  logic [LINE_W-1:0]   rd_data;
`ifdef L2_STAT_EN
  logic                hit_evt, miss_evt;
`endif

  l2_line_array u_lines (
    .clk      (clk),
    .clr      (proc_reset),
    .rd_idx   (l1_addr[IDX_W-1:0]),
    .rd_entry (rd_entry),
    .we       (fill_we),
    .wr_idx   (addr_q[IDX_W-1:0]),
    .wr_tag   (addr_q[ADDR_W-1:IDX_W]),
    .wr_data  (mem_rdata)
  );

  assign rd_valid = rd_entry[VALID_BIT];
  assign rd_tag   = rd_entry[TAG_LSB +: TAG_W];
  assign rd_data  = rd_entry[DATA_LSB +: LINE_W];
  assign hit      = rd_valid && (rd_tag == l1_addr[ADDR_W-1:IDX_W]);

  always_comb begin
    state_d    = state;
    addr_d     = addr_q;
    rdata_d    = l1_rdata;
    ready_d    = 1'b0;
    mem_read_d = mem_read;
    mem_addr_d = mem_addr;
    fill_we    = 1'b0;
`ifdef L2_STAT_EN
    hit_evt    = 1'b0;
    miss_evt   = 1'b0;
`endif
    case (state)
      IDLE: if (l1_read) begin
        addr_d = l1_addr;
        if (hit) begin
          rdata_d = rd_data;
          ready_d = 1'b1;
          state_d = RESP;
`ifdef L2_STAT_EN
          hit_evt = 1'b1;
`endif
        end else begin
          mem_read_d = 1'b1;
          mem_addr_d = l1_addr;
          state_d    = MISS;
`ifdef L2_STAT_EN
          miss_evt   = 1'b1;
`endif
        end
      end
      MISS: if (mem_ready) begin
        fill_we    = 1'b1;
        rdata_d    = mem_rdata;
        ready_d    = 1'b1;
        mem_read_d = 1'b0;
        mem_addr_d = '0;
        state_d    = RESP;
      end
      // L1 still holds l1_read during RESP, so it must not start a new lookup.
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      l1_rdata <= '0;
      l1_ready <= 1'b0;
      mem_read <= 1'b0;
      mem_addr <= '0;
    end else begin
      state    <= state_d;
      addr_q   <= addr_d;
      l1_rdata <= rdata_d;
      l1_ready <= ready_d;
      mem_read <= mem_read_d;
      mem_addr <= mem_addr_d;
    end
  end

`ifdef L2_STAT_EN
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if (hit_evt && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
      if (miss_evt && miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l2_read_cache.sv
// tb/tb_l2_read_cache.sv - randomized self-checking bench for l2_read_cache against an array-based cache model
module tb_l2_read_cache;
  import l2_cache_pkg::*;

  logic              clk = 1'b0;
  logic              proc_reset = 1'b0;
  logic              l1_read = 1'b0;
  logic [ADDR_W-1:0] l1_addr = '0;
  logic [LINE_W-1:0] l1_rdata;
  logic              l1_ready;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_rdata = '0;
  logic              mem_ready = 1'b0;
`ifdef L2_STAT_EN
  logic [15:0]       hit_cnt, miss_cnt;
`endif

  always #5 clk = ~clk;

  l2_read_cache dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .l1_read    (l1_read),
    .l1_addr    (l1_addr),
    .l1_rdata   (l1_rdata),
    .l1_ready   (l1_ready),
    .mem_read   (mem_read),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
`ifdef L2_STAT_EN
    ,
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  bit                m_valid [L2_LINES];
  logic [TAG_W-1:0]  m_tag   [L2_LINES];
  logic [LINE_W-1:0] m_data  [L2_LINES];
  int                n_hit, n_miss;

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [LINE_W-1:0] fill_byte(input logic [7:0] b);
    return {16{b}};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    proc_reset = 1'b1; l1_read = 1'b0; mem_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    proc_reset = 1'b0;
    for (int i = 0; i < L2_LINES; i++) m_valid[i] = 1'b0;
    n_hit = 0; n_miss = 0;
  endtask

  // One complete L1 request; the model decides hit/miss from the address alone.
  task automatic do_read(input logic [ADDR_W-1:0] addr, input logic [LINE_W-1:0] fill,
                         input int lat, input bit drop);
    int idx;
    logic [TAG_W-1:0] tag;
    logic [LINE_W-1:0] exp;
    bit hit;
    idx = int'(addr % L2_LINES);
    tag = TAG_W'(addr / L2_LINES);
    hit = m_valid[idx] && (m_tag[idx] == tag);
    exp = hit ? m_data[idx] : fill;
    @(negedge clk);
    l1_read = 1'b1; l1_addr = addr;
    @(posedge clk); @(negedge clk);
    if (!hit) begin
      n_miss++;
      checks++;
      if (mem_read !== 1'b1 || mem_addr !== addr || l1_ready !== 1'b0) begin
        errors++;
        $display("FAIL miss_req addr=%h: mem_read=%b mem_addr=%h l1_ready=%b, want 1 %h 0",
                 addr, mem_read, mem_addr, l1_ready, addr);
      end
      if (drop) l1_read = 1'b0;
      for (int i = 0; i < lat; i++) begin
        @(posedge clk); @(negedge clk);
        checks++;
        if (mem_read !== 1'b1 || mem_addr !== addr || l1_ready !== 1'b0) begin
          errors++;
          $display("FAIL miss_hold addr=%h cyc=%0d: mem_read=%b mem_addr=%h l1_ready=%b, want 1 %h 0",
                   addr, i, mem_read, mem_addr, l1_ready, addr);
        end
      end
      mem_ready = 1'b1; mem_rdata = fill;
      @(posedge clk); @(negedge clk);
      mem_ready = 1'b0; mem_rdata = rand_line();
      m_valid[idx] = 1'b1; m_tag[idx] = tag; m_data[idx] = fill;
    end else begin
      n_hit++;
    end
    checks++;
    if (l1_ready !== 1'b1 || l1_rdata !== exp || mem_read !== 1'b0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL resp addr=%h hit=%0d: l1_ready=%b mem_read=%b mem_addr=%h l1_rdata=%h, want 1 0 0 %h",
               addr, hit, l1_ready, mem_read, mem_addr, l1_rdata, exp);
    end
    l1_read = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (l1_ready !== 1'b0 || l1_rdata !== exp || mem_read !== 1'b0) begin
      errors++;
      $display("FAIL pulse_end addr=%h: l1_ready=%b mem_read=%b l1_rdata=%h, want 0 0 %h",
               addr, l1_ready, mem_read, l1_rdata, exp);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (l1_ready !== 1'b0 || l1_rdata !== '0 || mem_read !== 1'b0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_outputs: l1_ready=%b l1_rdata=%h mem_read=%b mem_addr=%h, want all 0",
               l1_ready, l1_rdata, mem_read, mem_addr);
    end
`ifdef L2_STAT_EN
    checks++;
    if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: hit=%0d miss=%0d, want 0 0", hit_cnt, miss_cnt);
    end
`endif
  endtask

  task automatic test_cold_miss_and_hit();
    do_read(28'h0000010, fill_byte(8'hA5), 0, 1'b0);
    do_read(28'h0000010, rand_line(), 0, 1'b0);
  endtask

  task automatic test_conflict();
    do_read(28'h0000050, fill_byte(8'h5A), 1, 1'b0);
    do_read(28'h0000010, rand_line(), 2, 1'b0);
    do_read(28'h0000010, rand_line(), 0, 1'b0);
  endtask

  task automatic test_slow_mem();
    do_read(28'h0ABCD17, rand_line(), 10, 1'b0);
    do_read(28'h0000000, rand_line(), 3, 1'b1);
    do_read(28'hFFFFFFF, rand_line(), 0, 1'b1);
    do_read(28'hFFFFFFF, rand_line(), 0, 1'b0);
  endtask

  task automatic test_spurious_mem_ready();
    @(negedge clk);
    mem_ready = 1'b1; mem_rdata = rand_line();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (l1_ready !== 1'b0 || mem_read !== 1'b0) begin
        errors++;
        $display("FAIL idle_mem_ready cyc=%0d: l1_ready=%b mem_read=%b, want 0 0", i, l1_ready, mem_read);
      end
    end
    do_read(28'h0000010, rand_line(), 0, 1'b0);
    mem_ready = 1'b0;
  endtask

  task automatic test_reset_mid_miss();
    apply_reset();
    @(negedge clk);
    l1_read = 1'b1; l1_addr = 28'h0000010;
    @(posedge clk); @(negedge clk);
    checks++;
    if (mem_read !== 1'b1) begin
      errors++;
      $display("FAIL rst_miss_start: mem_read=%b, want 1", mem_read);
    end
    proc_reset = 1'b1; l1_read = 1'b0;
    @(posedge clk); @(negedge clk);
    proc_reset = 1'b0;
    checks++;
    if (mem_read !== 1'b0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL rst_miss_drop: mem_read=%b mem_addr=%h, want 0 0", mem_read, mem_addr);
    end
    mem_ready = 1'b1; mem_rdata = rand_line();
    @(posedge clk); @(negedge clk);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (l1_ready !== 1'b0 || mem_read !== 1'b0) begin
        errors++;
        $display("FAIL rst_late_ready cyc=%0d: l1_ready=%b mem_read=%b, want 0 0", i, l1_ready, mem_read);
      end
      @(posedge clk); @(negedge clk);
    end
    for (int i = 0; i < L2_LINES; i++) m_valid[i] = 1'b0;
    n_hit = 0; n_miss = 0;
    do_read(28'h0000010, rand_line(), 1, 1'b0);
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] pool [6];
    pool[0] = 28'h0000000; pool[1] = 28'hFFFFFC0; pool[2] = 28'hFFFFFFF;
    pool[3] = 28'h0000003; pool[4] = 28'h0000043; pool[5] = 28'h1234567;
    for (int n = 0; n < 40; n++)
      do_read(pool[$urandom_range(0, 5)], rand_line(), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
`ifdef L2_STAT_EN
    checks++;
    if (hit_cnt !== 16'(n_hit) || miss_cnt !== 16'(n_miss)) begin
      errors++;
      $display("FAIL rand_counters: hit=%0d miss=%0d, want %0d %0d", hit_cnt, miss_cnt, n_hit, n_miss);
    end
`endif
  endtask

`ifdef L2_STAT_EN
  task automatic test_stats();
    apply_reset();
    do_read(28'h0000021, rand_line(), 0, 1'b0);
    do_read(28'h0000021, rand_line(), 0, 1'b0);
    do_read(28'h0000021, rand_line(), 0, 1'b0);
    do_read(28'h0000022, rand_line(), 2, 1'b0);
    do_read(28'h0000022, rand_line(), 0, 1'b0);
    do_read(28'h0000022, rand_line(), 0, 1'b0);
    do_read(28'h0000061, rand_line(), 1, 1'b0);
    do_read(28'h0000061, rand_line(), 0, 1'b0);
    checks++;
    if (hit_cnt !== 16'd5 || miss_cnt !== 16'd3) begin
      errors++;
      $display("FAIL stat_counts: hit=%0d miss=%0d, want 5 3", hit_cnt, miss_cnt);
    end
    apply_reset();
    checks++;
    if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin
      errors++;
      $display("FAIL stat_reset: hit=%0d miss=%0d, want 0 0", hit_cnt, miss_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss_and_hit();
    test_conflict();
    test_slow_mem();
    test_spurious_mem_ready();
    test_reset_mid_miss();
    test_random();
`ifdef L2_STAT_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
